// File: rtl/mode6_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mode6_sub_pipe (with helper mode6_fp_sub)
// Description : Softmax mode-6 subtract stage. Streams LANES fp words per
//               beat and computes x_i - max with a 2-stage valid/ready pipe.
//               Tracks the beat count per row and forwards a last-beat marker.
//               Optional macro MODE6_SUB_CLAMP_EN clamps positive results to
//               +0 and adds a sticky clamp_flag output.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef IEEE_COMPLIANCE
`define IEEE_COMPLIANCE 0
`endif

// ----------------------------------------------------------------------------
// mode6_fp_sub : combinational z = a - b, round-to-nearest-even. Behaves like
// DW_fp_sub with rnd=3'b000: zero-exponent inputs are zero, all-ones exponent
// inputs are infinity, tiny results flush to signed zero.
// ----------------------------------------------------------------------------
module mode6_fp_sub #(
    parameter int MANTISSA        = 10,
    parameter int EXPONENT        = 5,
    parameter int IEEE_COMPLIANCE = 0
) (
    input  logic [MANTISSA+EXPONENT:0] a,
    input  logic [MANTISSA+EXPONENT:0] b,
    output logic [MANTISSA+EXPONENT:0] z
);
    localparam int W    = MANTISSA + 1;   // significand incl. hidden bit
    localparam int WW   = W + 3;          // plus guard, round, sticky
    localparam int EMAX = (1 << EXPONENT) - 1;

    logic                sa, sb, sx, sy;
    logic [EXPONENT-1:0] ea, eb, ex, ey;
    logic [W-1:0]        ma, mb, mx, my;
    logic [2*W+2:0]      align;
    logic [WW-1:0]       ys;
    logic [WW:0]         sum, norm;
    logic [MANTISSA:0]   mant_r;
    logic                rnd, x_inf, y_inf;
    int                  d, lz, exp_r;

    // Align, add/subtract magnitudes, normalise and round.
    always_comb begin
        sa = a[MANTISSA+EXPONENT];
        sb = ~b[MANTISSA+EXPONENT];        // subtraction = addition of -b
        ea = a[MANTISSA+EXPONENT-1:MANTISSA];
        eb = b[MANTISSA+EXPONENT-1:MANTISSA];
        ma = (ea == '0) ? '0 : {1'b1, a[MANTISSA-1:0]};
        mb = (eb == '0) ? '0 : {1'b1, b[MANTISSA-1:0]};
        // Order operands so x has the larger magnitude.
        if ({eb, mb} > {ea, ma}) begin
            sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
        end else begin
            sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
        end
        x_inf = (ex == '1);
        y_inf = (ey == '1);
        d = int'(ex) - int'(ey);
        if (d > WW) d = WW;
        // Bits shifted past the low W positions are folded into sticky.
        align = {my, 3'b000, {W{1'b0}}} >> d;
        ys    = {align[2*W+2:W+1], align[W] | (|align[W-1:0])};
        if (sx == sy) sum = {1'b0, mx, 3'b000} + {1'b0, ys};
        else          sum = {1'b0, mx, 3'b000} - {1'b0, ys};
        lz = 0;
        for (int i = 0; i <= WW; i++) begin
            if (sum[i]) lz = WW - i;
        end
        norm   = sum << lz;
        rnd    = norm[3] & ((|norm[2:0]) | norm[4]);
        mant_r = {1'b0, norm[WW-1:4]} + {{MANTISSA{1'b0}}, rnd};
        exp_r  = int'(ex) + 1 - lz + int'(mant_r[MANTISSA]);
        if (x_inf && y_inf && (sx != sy)) begin
            // inf - inf: NaN when compliant, otherwise +inf
            z = {1'b0, {EXPONENT{1'b1}}, (IEEE_COMPLIANCE != 0), {(MANTISSA-1){1'b0}}};
        end else if (x_inf) begin
            z = {sx, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
        end else if (sum == '0) begin
            z = '0;                        // exact cancellation gives +0 under RNE
        end else if (exp_r <= 0) begin
            z = {sx, {(MANTISSA+EXPONENT){1'b0}}};
        end else if (exp_r >= EMAX) begin
            z = {sx, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
        end else begin
            z = {sx, exp_r[EXPONENT-1:0], mant_r[MANTISSA-1:0]};
        end
    end
endmodule

// ----------------------------------------------------------------------------
// mode6_sub_pipe : top level pipe
// ----------------------------------------------------------------------------
module mode6_sub_pipe #(
    parameter int LANES           = 4,
    parameter int DATAWIDTH       = `DATAWIDTH,
    parameter int MANTISSA        = `MANTISSA,
    parameter int EXPONENT        = `EXPONENT,
    parameter int IEEE_COMPLIANCE = `IEEE_COMPLIANCE,
    parameter int CNT_W           = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       b_load,
    input  logic [DATAWIDTH-1:0]       b_value,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [LANES*DATAWIDTH-1:0] a_inp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [LANES*DATAWIDTH-1:0] outp,
    output logic [CNT_W-1:0]           beat_cnt,
    output logic                       row_done
`ifdef MODE6_SUB_CLAMP_EN
    ,
    output logic                       clamp_flag
`endif
);
    logic [DATAWIDTH-1:0]       b_reg, b_sel, s1_b;
    logic [LANES*DATAWIDTH-1:0] s1_a, s2_next;
    logic                       s1_valid, s1_last, adv, in_fire;

    assign adv      = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv;
    assign in_fire  = in_valid && in_ready;
    // A beat accepted alongside b_load sees the new max immediately.
    assign b_sel    = b_load ? b_value : b_reg;

`ifdef MODE6_SUB_CLAMP_EN
    logic [LANES-1:0] clamp_hit;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATAWIDTH-1:0] diff;
        mode6_fp_sub #(
            .MANTISSA       (MANTISSA),
            .EXPONENT       (EXPONENT),
            .IEEE_COMPLIANCE(IEEE_COMPLIANCE)
        ) u_sub (
            .a(s1_a[i*DATAWIDTH +: DATAWIDTH]),
            .b(s1_b),
            .z(diff)
        );
`ifdef MODE6_SUB_CLAMP_EN
        // A positive nonzero result means the loaded max was too small.
        assign clamp_hit[i] = !diff[DATAWIDTH-1] && (|diff[DATAWIDTH-2:0]);
        assign s2_next[i*DATAWIDTH +: DATAWIDTH] = clamp_hit[i] ? '0 : diff;
`else
        assign s2_next[i*DATAWIDTH +: DATAWIDTH] = diff;
`endif
    end

    // Max register: loads whenever b_load is high.
    always_ff @(posedge clk) begin
        if (reset)       b_reg <= '0;
        else if (b_load) b_reg <= b_value;
    end

    // Stage 1: capture the operand beat with its own copy of the max.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_last  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= a_inp;
                s1_b    <= b_sel;
                s1_last <= in_last;
            end
        end
    end

    // Stage 2: register the differences; hold while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            outp      <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                outp     <= s2_next;
                out_last <= s1_last;
            end
        end
    end

    // Beat counter: counts accepted beats, restarts after the last beat.
    always_ff @(posedge clk) begin
        if (reset)        beat_cnt <= '0;
        else if (in_fire) beat_cnt <= in_last ? '0 : beat_cnt + 1'b1;
    end

    // Row-done pulse after the last beat of a row leaves the pipe.
    always_ff @(posedge clk) begin
        if (reset) row_done <= 1'b0;
        else       row_done <= out_valid && out_ready && out_last;
    end

`ifdef MODE6_SUB_CLAMP_EN
    // Sticky clamp indicator; a new max starts a fresh observation window.
    always_ff @(posedge clk) begin
        if (reset || b_load)                    clamp_flag <= 1'b0;
        else if (adv && s1_valid && |clamp_hit) clamp_flag <= 1'b1;
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_mode6_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode6_sub_pipe
// Description : Self-checking bench for mode6_sub_pipe (LANES=4, fp16).
//               Reference results come from real-valued subtraction rounded
//               back to fp16; a queue scoreboard tracks beats in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mode6_sub_pipe;
    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  b_load = 1'b0;
    logic [DW-1:0]         b_value = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic                  in_last = 1'b0;
    logic [LANES*DW-1:0]   a_inp = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic                  out_last;
    logic [LANES*DW-1:0]   outp;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  row_done;
`ifdef MODE6_SUB_CLAMP_EN
    logic                  clamp_flag;
`endif

    mode6_sub_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .b_load(b_load), .b_value(b_value),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a_inp(a_inp), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .outp(outp), .beat_cnt(beat_cnt),
        .row_done(row_done)
`ifdef MODE6_SUB_CLAMP_EN
        , .clamp_flag(clamp_flag)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        int  e = int'(h[14:10]);
        real r;
        if (e == 0) return 0.0;
        r = (1.0 + real'(h[9:0]) / 1024.0) * pow2(e - 15);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        real    m, rem;
        int     e, n;
        logic   sg;
        logic [4:0] ef;
        logic [9:0] mf;
        if (r == 0.0) return 16'h0000;
        sg = (r < 0.0);
        m  = sg ? -r : r;
        e  = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        n   = $rtoi(m * 1024.0);
        rem = m * 1024.0 - real'(n);
        if (rem > 0.5 || (rem == 0.5 && (n % 2) == 1)) n++;
        if (n == 2048) begin n = 1024; e++; end
        ef = 5'(e + 15);
        mf = 10'(n - 1024);
        return {sg, ef, mf};
    endfunction

    function automatic logic [63:0] model_beat(input logic [63:0] a, input logic [15:0] b);
        logic [63:0] res;
        logic [15:0] r;
        for (int i = 0; i < LANES; i++) begin
            r = r2h(h2r(a[i*DW +: DW]) - h2r(b));
`ifdef MODE6_SUB_CLAMP_EN
            if (!r[15] && r[14:0] != 15'd0) r = 16'h0000;
`endif
            res[i*DW +: DW] = r;
        end
        return res;
    endfunction

    function automatic logic [15:0] rnd_half();
        logic       s  = 1'($urandom_range(0, 1));
        logic [4:0] e  = 5'($urandom_range(13, 18));
        logic [9:0] m  = 10'($urandom);
        return {s, e, m};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    typedef struct { logic [63:0] d; logic last; } exp_t;
    exp_t        sb_q[$];
    logic [15:0] m_b   = '0;
    logic [7:0]  m_cnt = '0;
    logic        m_rd  = 1'b0;
    bit          mon_en = 1'b0;
    bit          blocked_seen = 1'b0;
    int          rd_count = 0;

    // Compare state against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
            check("row_done", 64'(row_done), 64'(m_rd));
            if (row_done) rd_count++;
            if (in_valid && !in_ready) blocked_seen = 1'b1;
            m_rd = 1'b0;
            if (reset) begin
                sb_q.delete();
                m_cnt = '0;
                m_b   = '0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_out", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("outp", outp, e.d);
                        check("out_last", 64'(out_last), 64'(e.last));
                        m_rd = e.last;
                    end
                end
                if (in_valid && in_ready) begin
                    e.d    = model_beat(a_inp, b_load ? b_value : m_b);
                    e.last = in_last;
                    sb_q.push_back(e);
                    m_cnt = in_last ? 8'd0 : m_cnt + 8'd1;
                end
                if (b_load) m_b = b_value;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; b_load = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outp", outp, 64'd0);
        check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        check("rst_row_done", 64'(row_done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [63:0] a, input logic last, input logic ld, input logic [15:0] bv);
        bit acc = 1'b0;
        in_valid = 1'b1; a_inp = a; in_last = last; b_load = ld; b_value = bv;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0; b_load = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [63:0] a0, a1, a2, a3;

    initial begin
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;

        // Basic subtract: max = 3.0
        do_reset();
        send(64'h4200_3C00_0000_4400, 1'b0, 1'b1, 16'h4200);
        check("basic_lat1_valid", 64'(out_valid), 64'd0);
        idle(1);
        check("basic_valid", 64'(out_valid), 64'd1);
`ifdef MODE6_SUB_CLAMP_EN
        check("basic_outp", outp, 64'h0000_C000_C200_0000);
`else
        check("basic_outp", outp, 64'h0000_C000_C200_3C00);
`endif
        idle(1);
        check("basic_valid_once", 64'(out_valid), 64'd0);

        // Back-pressure: out_ready low for 5 cycles from cycle 2
        do_reset();
        blocked_seen = 1'b0;
        a0 = 64'h4400_4500_4600_4700;
        a1 = 64'h3800_3C00_4000_4200;
        a2 = 64'hC000_4200_4400_3400;
        a3 = 64'h4900_4800_4880_4A00;
        fork
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2;
                check("bp_hold_valid", 64'(out_valid), 64'd1);
                check("bp_hold_outp", outp, model_beat(a0, 16'h4200));
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        send(a0, 1'b0, 1'b1, 16'h4200);
        send(a1, 1'b0, 1'b0, 16'h0000);
        send(a2, 1'b0, 1'b0, 16'h0000);
        send(a3, 1'b0, 1'b0, 16'h0000);
        idle(10);
        check("bp_in_ready_dropped", 64'(blocked_seen), 64'd1);
        check("bp_drained", 64'(sb_q.size()), 64'd0);

        // Same-cycle b_load bypass, then b_load while the beat is stalled
        do_reset();
        out_ready = 1'b0;
        send({4{16'h3C00}}, 1'b0, 1'b1, 16'h3C00);
        b_load = 1'b1; b_value = 16'h4000;
        idle(1);
        b_load = 1'b0;
        idle(2);
        check("byp_stalled_valid", 64'(out_valid), 64'd1);
        check("byp_stalled_outp", outp, 64'd0);
        out_ready = 1'b1;
        idle(1);
        send({4{16'h4000}}, 1'b0, 1'b0, 16'h0000);
        idle(1);
        check("byp_next_valid", 64'(out_valid), 64'd1);
        check("byp_next_outp", outp, 64'd0);
        idle(2);

        // Row control: 3 beats, last on the 3rd
        do_reset();
        rd_count = 0;
        send(64'h4000_4100_4200_4300, 1'b0, 1'b1, 16'h4400);
        check("row_cnt1", 64'(beat_cnt), 64'd1);
        send(64'h3C00_3E00_4000_4100, 1'b0, 1'b0, 16'h0000);
        check("row_cnt2", 64'(beat_cnt), 64'd2);
        send(64'h4400_4300_4200_4100, 1'b1, 1'b0, 16'h0000);
        check("row_cnt0", 64'(beat_cnt), 64'd0);
        idle(6);
        check("row_done_once", 64'(rd_count), 64'd1);

        // Reset mid-row discards in-flight beats
        do_reset();
        out_ready = 1'b0;
        send(64'h4000_4000_4000_4000, 1'b0, 1'b1, 16'h3C00);
        send(64'h4100_4100_4100_4100, 1'b0, 1'b0, 16'h0000);
        do_reset();
        idle(6);
        check("midrst_no_stale", 64'(sb_q.size()), 64'd0);

`ifdef MODE6_SUB_CLAMP_EN
        // Clamp: a > b forces +0 and sets the sticky flag
        do_reset();
        send({4{16'h4000}}, 1'b0, 1'b1, 16'h3C00);
        idle(1);
        check("clamp_outp", outp, 64'd0);
        check("clamp_flag_set", 64'(clamp_flag), 64'd1);
        b_load = 1'b1; b_value = 16'h4400;
        idle(1);
        b_load = 1'b0;
        check("clamp_flag_clear", 64'(clamp_flag), 64'd0);
`endif

        // Randomised traffic with random stalls and max reloads
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            b_load    = ($urandom_range(0, 9) == 0);
            b_value   = rnd_half();
            in_last   = ($urandom_range(0, 4) == 0);
            a_inp     = {rnd_half(), rnd_half(), rnd_half(), rnd_half()};
            idle(1);
        end
        in_valid = 1'b0; b_load = 1'b0; out_ready = 1'b1;
        idle(6);
        check("rand_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
